// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with write-back plus a one-entry valid/ready output stage.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle write-back data into accepted operands.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  ALUsrc,
    input  logic                  ALUctrl_in,
    input  logic                  flush,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wad,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic                  ALUctrl,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int NREGS  = 1 << ADDR_WIDTH;
    localparam int A0_IDX = 10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] rf_q [NREGS];

    // Register 0 is a constant; every other entry clears asynchronously so a0 drops during reset.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        rf_q[gi] <= '0;
                    end else if (we && (wad == ADDR_WIDTH'(gi))) begin
                        rf_q[gi] <= wd;
                    end
                end
            end
        end
    endgenerate

    assign a0 = rf_q[A0_IDX];

    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

`ifdef OPERAND_FETCH_BYPASS_EN
    logic wr_live;
    assign wr_live = we && (wad != '0);
    assign rs1_val = (wr_live && (wad == rs1)) ? wd : rf_q[rs1];
    assign rs2_val = (wr_live && (wad == rs2)) ? wd : rf_q[rs2];
`else
    assign rs1_val = rf_q[rs1];
    assign rs2_val = rf_q[rs2];
`endif

    state_t state_q;
    state_t state_d;
    logic   accept;

    // A flushed cycle never accepts, so neither the state nor the data registers load.
    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = !out_valid || out_ready;
    end

    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op1_d;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [DATA_WIDTH-1:0] op2_d;
    logic                  ctrl_q;
    logic                  ctrl_d;

    always_comb begin
        op1_d  = op1_q;
        op2_d  = op2_q;
        ctrl_d = ctrl_q;
        if (accept) begin
            op1_d  = rs1_val;
            op2_d  = ALUsrc ? imm : rs2_val;
            ctrl_d = ALUctrl_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q  <= '0;
            op2_q  <= '0;
            ctrl_q <= 1'b0;
        end else begin
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign ALUop1  = op1_q;
    assign ALUop2  = op2_q;
    assign ALUctrl = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, reset corner cases, randomized model check.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        ALUsrc = 1'b0;
    logic        ALUctrl_in = 1'b0;
    logic        flush = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wad = '0;
    logic [31:0] wd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUop1;
    logic [31:0] ALUop2;
    logic        ALUctrl;
    logic [31:0] a0;

    int total = 0;
    int bad = 0;

    operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm),
        .ALUsrc(ALUsrc), .ALUctrl_in(ALUctrl_in), .flush(flush),
        .we(we), .wad(wad), .wd(wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl), .a0(a0)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        src;
        logic        ctrl;
        logic        fl;
        logic        ordy;
        logic        we;
        logic [4:0]  wad;
        logic [31:0] wd;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic        e_ctrl;
        logic [31:0] e_a0;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [4:0] r1, logic [4:0] r2, logic [31:0] im,
                                logic src, logic ctl, logic fl, logic ordy,
                                logic w, logic [4:0] wa, logic [31:0] wdat,
                                logic e_rdy, logic e_val, logic [31:0] e_op1,
                                logic [31:0] e_op2, logic e_ctrl, logic [31:0] e_a0);
        vec_t v;
        v.iv = iv; v.rs1 = r1; v.rs2 = r2; v.imm = im; v.src = src; v.ctrl = ctl;
        v.fl = fl; v.ordy = ordy; v.we = w; v.wad = wa; v.wd = wdat;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_op1 = e_op1; v.e_op2 = e_op2;
        v.e_ctrl = e_ctrl; v.e_a0 = e_a0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] im, input logic src, input logic ctl,
                         input logic fl, input logic ordy,
                         input logic w, input logic [4:0] wa, input logic [31:0] wdat);
        in_valid = iv; rs1 = r1; rs2 = r2; imm = im; ALUsrc = src; ALUctrl_in = ctl;
        flush = fl; out_ready = ordy; we = w; wad = wa; wd = wdat;
    endtask

    // Reference model: architectural register array plus the held request.
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic        m_ctrl;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && we && wad != 5'd0 && wad == a) return wd;
        return m_rf[a];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_ctrl = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] byp_op1;
        logic        e_rdy, acc;
        byp_op1 = BYP ? 32'h0000_00AA : 32'h0000_0011;
        //            iv rs1 rs2 imm           src ctl fl ordy we wad wd           rdy val op1          op2           ctl a0
        vecs[0]  = mk(0, 0, 0, 32'h0,          0, 0, 0, 0, 1, 5, 32'h7,        1, 0, 32'h0,        32'h0,        0, 32'h0);
        vecs[1]  = mk(1, 5, 0, 32'hFFFF_FFFF,  1, 0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h7,        32'hFFFF_FFFF, 0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 0, 32'h0,        1, 0, 32'h7,        32'hFFFF_FFFF, 0, 32'h0);
        vecs[3]  = mk(1, 0, 0, 32'h0,          0, 0, 0, 0, 1, 0, 32'h1234,     1, 1, 32'h0,        32'h0,        0, 32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h0);
        vecs[5]  = mk(1, 5, 0, 32'hFFFF_FFFF,  1, 1, 0, 0, 0, 0, 32'h0,        1, 1, 32'h7,        32'hFFFF_FFFF, 1, 32'h0);
        vecs[6]  = mk(1, 5, 0, 32'h0,          0, 0, 0, 0, 1, 5, 32'h9,        0, 1, 32'h7,        32'hFFFF_FFFF, 1, 32'h0);
        vecs[7]  = mk(1, 5, 0, 32'h0,          0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h7,        32'hFFFF_FFFF, 1, 32'h0);
        vecs[8]  = mk(1, 5, 0, 32'h0,          0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h7,        32'hFFFF_FFFF, 1, 32'h0);
        vecs[9]  = mk(1, 5, 0, 32'h0,          0, 0, 0, 1, 0, 0, 32'h0,        1, 1, 32'h9,        32'h0,        0, 32'h0);
        vecs[10] = mk(0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 0, 32'h0,        1, 0, 32'h9,        32'h0,        0, 32'h0);
        vecs[11] = mk(0, 0, 0, 32'h0,          0, 0, 0, 1, 1, 3, 32'h11,       1, 0, 32'h9,        32'h0,        0, 32'h0);
        vecs[12] = mk(1, 3, 0, 32'h5,          1, 1, 0, 1, 1, 3, 32'hAA,       1, 1, byp_op1,      32'h5,        1, 32'h0);
        vecs[13] = mk(1, 3, 0, 32'h7,          1, 0, 1, 1, 1, 10, 32'd42,      1, 0, byp_op1,      32'h5,        1, 32'd42);

        // Reset state, checked while rst_n is still low.
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op1", ALUop1, 32'd0);
        chk("rst_a0", a0, 32'd0);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].src, vecs[i].ctrl,
                  vecs[i].fl, vecs[i].ordy, vecs[i].we, vecs[i].wad, vecs[i].wd);
            #2;
            chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_val));
            chk($sformatf("row%0d_op1", i), ALUop1, vecs[i].e_op1);
            chk($sformatf("row%0d_op2", i), ALUop2, vecs[i].e_op2);
            chk($sformatf("row%0d_ctrl", i), 32'(ALUctrl), 32'(vecs[i].e_ctrl));
            chk($sformatf("row%0d_a0", i), a0, vecs[i].e_a0);
            $display("row %0d: iv=%0b rs1=%0d fl=%0b ordy=%0b we=%0b wad=%0d -> out_valid=%0b op1=%h op2=%h a0=%h",
                     i, vecs[i].iv, vecs[i].rs1, vecs[i].fl, vecs[i].ordy, vecs[i].we, vecs[i].wad,
                     out_valid, ALUop1, ALUop2, a0);
        end

        // Mid-stall asynchronous reset: outputs must drop before any clock edge.
        drive(1, 10, 0, 32'h55, 1, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        drive(1, 10, 0, 32'h55, 1, 1, 0, 0, 1, 10, 32'd77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_op1", ALUop1, 32'd0);
        chk("async_rst_op2", ALUop2, 32'd0);
        chk("async_rst_a0", a0, 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1, 0, 0, 32'h123, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_a0_write_ignored", a0, 32'd0);
        @(posedge clk);
        #1;
        chk("first_accept_valid", 32'(out_valid), 32'd1);
        chk("first_accept_op2", ALUop2, 32'h123);
        $display("reset sequence: out_valid=%0b op2=%h a0=%h", out_valid, ALUop2, a0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [4:0] wa;
            wa = ($urandom_range(0, 5) == 0) ? 5'd10 : 5'($urandom_range(1, 7));
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 10)), 5'($urandom_range(0, 10)),
                  $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
                  1'($urandom_range(0, 1)), wa, $urandom);
            #2;
            e_rdy = !m_valid || out_ready;
            chk("rand_in_ready", 32'(in_ready), 32'(e_rdy));
            chk("rand_a0", a0, m_rf[10]);
            acc = in_valid && e_rdy && !flush;
            if (acc) begin
                m_op1  = m_read(rs1);
                m_op2  = ALUsrc ? imm : m_read(rs2);
                m_ctrl = ALUctrl_in;
            end
            if (flush)          m_valid = 1'b0;
            else if (acc)       m_valid = 1'b1;
            else if (out_ready) m_valid = 1'b0;
            if (we && wad != 5'd0) m_rf[wad] = wd;
            @(posedge clk);
            #1;
            chk("rand_out_valid", 32'(out_valid), 32'(m_valid));
            chk("rand_op1", ALUop1, m_op1);
            chk("rand_op2", ALUop2, m_op2);
            chk("rand_ctrl", 32'(ALUctrl), 32'(m_ctrl));
            if (acc)
                $display("rand %0d: accept rs1=%0d rs2=%0d src=%0b -> op1=%h op2=%h",
                         c, rs1, rs2, ALUsrc, ALUop1, ALUop2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register and operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the register index width (2^ADDR_WIDTH registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  decode presents an operand request.
REQ-006 SHALL have port in_ready  output  1  stage can accept a request this cycle.
REQ-007 SHALL have port rs1  input  ADDR_WIDTH  source register 1 index.
REQ-008 SHALL have port rs2  input  ADDR_WIDTH  source register 2 index.
REQ-009 SHALL have port imm  input  DATA_WIDTH  sign-extended immediate.
REQ-010 SHALL have port ALUsrc  input  1  1 selects imm as operand 2, 0 selects register rs2.
REQ-011 SHALL have port ALUctrl_in  input  1  ALU operation (0 add, 1 compare-equal), passed through.
REQ-012 SHALL have port flush  input  1  discard held request (taken branch).
REQ-013 SHALL have port we  input  1  write-back enable.
REQ-014 SHALL have port wad  input  ADDR_WIDTH  write-back register index.
REQ-015 SHALL have port wd  input  DATA_WIDTH  write-back data.
REQ-016 SHALL have port out_valid  output  1  ALUop1/ALUop2/ALUctrl hold a valid request.
REQ-017 SHALL have port out_ready  input  1  execute stage consumes the held request.
REQ-018 SHALL have port ALUop1  output  DATA_WIDTH  operand 1 to ALU.
REQ-019 SHALL have port ALUop2  output  DATA_WIDTH  operand 2 to ALU.
REQ-020 SHALL have port ALUctrl  output  1  registered ALU operation select.
REQ-021 SHALL have port a0  output  DATA_WIDTH  current contents of register 10 (combinational from array).

Function
REQ-022 SHALL hold 2^ADDR_WIDTH registers of DATA_WIDTH bits; register 0 always reads 0 and ignores writes.
REQ-023 SHALL write wd into register wad at the rising edge when we=1 and wad!=0.
REQ-024 SHALL implement a one-entry output stage with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-025 SHALL drive in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-026 SHALL accept a request when in_valid && in_ready; output registers load at that edge, latency exactly 1 cycle.
REQ-027 SHALL load ALUop1 = reg[rs1], ALUop2 = ALUsrc ? imm : reg[rs2], ALUctrl = ALUctrl_in on accept.
REQ-028 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept (back-to-back, no bubble).
REQ-029 SHALL keep ALUop1, ALUop2, ALUctrl stable while out_valid=1 and out_ready=0, even if the source registers are rewritten.
REQ-030 SHALL, on flush=1, force EMPTY at the next edge and ignore any same-cycle accept; flush overrides out_ready and in_valid.
REQ-031 SHALL leave output data registers unchanged when no accept occurs (only out_valid changes).
REQ-032 SHALL perform write-back independently of handshake and flush (writes proceed during stall and flush).

Reset
REQ-033 SHALL, while rst_n=0, asynchronously clear all registers, out_valid, ALUop1, ALUop2, ALUctrl to 0; in_ready=1 and a0=0 follow.
REQ-034 SHALL discard any held request and ignore writes asserted during reset; first accept possible at the first edge after rst_n rises.

Configuration
REQ-035 SHALL support macro OPERAND_FETCH_BYPASS_EN.
REQ-036 With OPERAND_FETCH_BYPASS_EN defined, an accept in the same cycle as a write (we=1, wad!=0) to rs1 or rs2 SHALL capture wd for that operand.
REQ-037 Without OPERAND_FETCH_BYPASS_EN, that accept SHALL capture the old register value; the write still completes.

Verification
REQ-038 Reset then write x5=0x0000_0007, accept rs1=5, ALUsrc=1, imm=0xFFFF_FFFF -> next cycle out_valid=1, ALUop1=7, ALUop2=0xFFFF_FFFF.
REQ-039 Write x0=0x1234, accept rs1=0, rs2=0, ALUsrc=0 -> ALUop1=0, ALUop2=0.
REQ-040 Hold out_ready=0 three cycles with in_valid=1, rewrite x5=9 -> in_ready=0, outputs unchanged at 7; raise out_ready -> new request accepted same cycle, no bubble.
REQ-041 Same-cycle we=1, wad=3, wd=0xAA and accept rs1=3 (x3 previously 0x11) -> ALUop1=0xAA with OPERAND_FETCH_BYPASS_EN, 0x11 without.
REQ-042 flush=1 coincident with accept and out_ready=1 -> out_valid=0 next cycle; write x10=42 same cycle -> a0=42.
REQ-043 Assert rst_n=0 mid-stall with out_valid=1 -> out_valid, ALUop1, ALUop2, a0 read 0 immediately, before the next clock edge.
